// File: rtl/isa_bus_master.sv
// rtl/isa_bus_master.sv - ISA bus cycle generator: req/ack handshake to sequenced 8-bit I/O or memory cycle
module isa_bus_master #(
    parameter int SETUP_CYCLES   = 1,
    parameter int CMD_CYCLES     = 4,
    parameter int HOLD_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        req,
    input  logic        req_we,
    input  logic        req_io,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        timeout,
    output logic [19:0] bus_a,
    output logic        bus_aen,
    output logic        bus_ior_l,
    output logic        bus_iow_l,
    output logic        bus_memr_l,
    output logic        bus_memw_l,
    output logic [7:0]  bus_d,
    output logic        bus_d_oe,
    input  logic [7:0]  bus_in,
    input  logic        bus_rdy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam logic [7:0]  SETUP_LOAD = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0]  CMD_LOAD   = 8'(CMD_CYCLES - 1);
    localparam logic [7:0]  HOLD_LOAD  = 8'(HOLD_CYCLES - 1);
    localparam logic [15:0] TO_LIMIT   = 16'(TIMEOUT_CYCLES);
    localparam logic        TO_EN      = (TIMEOUT_CYCLES != 0);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] wait_q, wait_d;
    logic        we_q, we_d;
    logic        io_q, io_d;
    logic [19:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        to_q, to_d;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            wait_q  <= 16'd0;
            we_q    <= 1'b0;
            io_q    <= 1'b0;
            addr_q  <= 20'd0;
            wdata_q <= 8'd0;
            rdata_q <= 8'd0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            we_q    <= we_d;
            io_q    <= io_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        we_d    = we_q;
        io_d    = io_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        to_d    = to_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                    we_d    = req_we;
                    io_d    = req_io;
                    addr_d  = req_io ? {4'h0, req_addr[15:0]} : req_addr;
                    wdata_d = req_wdata;
                    to_d    = 1'b0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_CMD;
                    cnt_d   = CMD_LOAD;
                    wait_d  = 16'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_CMD: begin
                // bus_rdy only matters once the minimum strobe width has elapsed
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (bus_rdy) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    if (!we_q) begin
                        rdata_d = bus_in;
                    end
                end else if (TO_EN && (wait_q == TO_LIMIT)) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    to_d    = 1'b1;
                    rdata_d = 8'hFF;
                end else if (wait_q != 16'hFFFF) begin
                    wait_d = wait_q + 16'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    logic busy;
    logic in_cmd;

    // Outputs decode from registered state so reset forces them idle without waiting for an edge
    assign busy       = (state_q == ST_SETUP) || (state_q == ST_CMD) || (state_q == ST_HOLD);
    assign in_cmd     = (state_q == ST_CMD);
    assign bus_aen    = ~busy;
    assign bus_d_oe   = busy & we_q;
    assign bus_a      = addr_q;
    assign bus_d      = wdata_q;
    assign bus_ior_l  = ~(in_cmd &  io_q & ~we_q);
    assign bus_iow_l  = ~(in_cmd &  io_q &  we_q);
    assign bus_memr_l = ~(in_cmd & ~io_q & ~we_q);
    assign bus_memw_l = ~(in_cmd & ~io_q &  we_q);
    assign ack        = (state_q == ST_DONE);
    assign timeout    = (state_q == ST_DONE) & to_q;
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_isa_bus_master.sv
// tb/tb_isa_bus_master.sv - randomized self-checking bench for isa_bus_master against a cycle-timeline model
module tb_isa_bus_master;

    localparam int S = 1;
    localparam int C = 4;
    localparam int H = 1;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset_l;
    logic        req, req_we, req_io;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        ack, timeout;
    logic [7:0]  rdata;
    logic [19:0] bus_a;
    logic        bus_aen, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l;
    logic [7:0]  bus_d;
    logic        bus_d_oe;
    logic [7:0]  bus_in;
    logic        bus_rdy;

    int n_cmp = 0;
    int n_bad = 0;

    logic        rdy_tab [0:31];
    logic [7:0]  in_tab  [0:31];
    logic [19:0] last_a     = 20'd0;
    logic [7:0]  last_rdata = 8'd0;

    isa_bus_master #(
        .SETUP_CYCLES(S), .CMD_CYCLES(C), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .reset_l(reset_l),
        .req(req), .req_we(req_we), .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
        .ack(ack), .rdata(rdata), .timeout(timeout),
        .bus_a(bus_a), .bus_aen(bus_aen),
        .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l), .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l),
        .bus_d(bus_d), .bus_d_oe(bus_d_oe), .bus_in(bus_in), .bus_rdy(bus_rdy)
    );

    always #5 clk = ~clk;

    wire [3:0] strb = {bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        chk("one_strobe", 32'($countones(~strb) <= 1), 32'd1);
    end

    // mode 0: ready, 1: random, 2: stuck low, 3: low only before the last counted cycle, 4: n waits
    task automatic fill(input int mode, input logic [7:0] din, input bit rand_din);
        int n;
        n = $urandom_range(T - 1, 0);
        for (int i = 0; i < 32; i++) begin
            case (mode)
                0: rdy_tab[i] = 1'b1;
                1: rdy_tab[i] = 1'($urandom);
                2: rdy_tab[i] = 1'b0;
                3: rdy_tab[i] = (i >= S + C);
                default: rdy_tab[i] = (i >= S + C + n);
            endcase
            in_tab[i] = rand_din ? 8'($urandom) : din;
        end
    endtask

    task automatic run_txn(input logic we, input logic io, input logic [19:0] addr,
                           input logic [7:0] wd, input bit hold_req);
        int w, e, ackc, sel;
        logic to;
        logic [19:0] ea;
        logic [7:0] er;
        logic [3:0] es;
        bit in_cyc;
        w = 0;
        to = 1'b0;
        forever begin
            if (rdy_tab[S + C + w]) break;
            if (w == T) begin
                to = 1'b1;
                break;
            end
            w++;
        end
        e    = S + C + w;
        ackc = e + H + 1;
        ea   = io ? {4'h0, addr[15:0]} : addr;
        er   = to ? 8'hFF : (we ? last_rdata : in_tab[e]);
        sel  = io ? (we ? 2 : 3) : (we ? 0 : 1);
        for (int k = 0; k <= ackc; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req = 1'b1; req_we = we; req_io = io; req_addr = addr; req_wdata = wd;
            end
            bus_rdy = rdy_tab[k];
            bus_in  = in_tab[k];
            #1;
            in_cyc = (k >= 1) && (k <= e + H);
            es = 4'hF;
            if (k >= S + 1 && k <= e) es[sel] = 1'b0;
            chk("strobes", 32'(strb), 32'(es));
            chk("aen", 32'(bus_aen), 32'(!in_cyc));
            chk("d_oe", 32'(bus_d_oe), 32'(in_cyc && we));
            chk("ack", 32'(ack), 32'(k == ackc));
            if (k == 0) chk("a_hold", 32'(bus_a), 32'(last_a));
            if (in_cyc) chk("bus_a", 32'(bus_a), 32'(ea));
            if (in_cyc && we) chk("bus_d", 32'(bus_d), 32'(wd));
            if (k == ackc) begin
                chk("timeout", 32'(timeout), 32'(to));
                chk("rdata", 32'(rdata), 32'(er));
            end
        end
        if (!hold_req) req = 1'b0;
        last_a     = ea;
        last_rdata = er;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req = 1'b0;
            bus_rdy = 1'($urandom);
            #1;
            chk("idle_aen", 32'(bus_aen), 32'd1);
            chk("idle_strb", 32'(strb), 32'hF);
            chk("idle_ack", 32'(ack), 32'd0);
            chk("idle_a", 32'(bus_a), 32'(last_a));
            chk("idle_rdata", 32'(rdata), 32'(last_rdata));
        end
    endtask

    task automatic reset_mid_write();
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_io = 1'b0; req_addr = 20'hA5C3E; req_wdata = 8'h77; bus_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_pre_memw", 32'(bus_memw_l), 32'd0);
        reset_l = 1'b0;
        #1;
        chk("rst_memw", 32'(bus_memw_l), 32'd1);
        chk("rst_aen", 32'(bus_aen), 32'd1);
        chk("rst_d_oe", 32'(bus_d_oe), 32'd0);
        chk("rst_a", 32'(bus_a), 32'd0);
        chk("rst_d", 32'(bus_d), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_l = 1'b1;
        last_a = 20'd0;
        last_rdata = 8'd0;
        idle(10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        reset_l = 1'b0; req = 1'b0; req_we = 1'b0; req_io = 1'b0;
        req_addr = 20'd0; req_wdata = 8'd0; bus_in = 8'd0; bus_rdy = 1'b1;
        #1;
        chk("reset_aen", 32'(bus_aen), 32'd1);
        chk("reset_strb", 32'(strb), 32'hF);
        chk("reset_d_oe", 32'(bus_d_oe), 32'd0);
        chk("reset_a", 32'(bus_a), 32'd0);
        chk("reset_d", 32'(bus_d), 32'd0);
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_timeout", 32'(timeout), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_l = 1'b1;
        idle(2);

        fill(0, 8'h00, 1'b1);
        run_txn(1'b1, 1'b1, 20'h003D8, 8'h29, 1'b0);
        idle(2);
        fill(0, 8'hF9, 1'b0);
        run_txn(1'b0, 1'b1, 20'hF03DA, 8'h00, 1'b0);
        idle(1);
        fill(0, 8'h41, 1'b0);
        for (int i = 5; i <= 7; i++) rdy_tab[i] = 1'b0;
        run_txn(1'b0, 1'b0, 20'hB8000, 8'h00, 1'b0);
        idle(1);
        fill(2, 8'h5A, 1'b0);
        run_txn(1'b0, 1'b0, 20'hB8002, 8'h00, 1'b0);
        fill(0, 8'h13, 1'b0);
        run_txn(1'b0, 1'b0, 20'hB8004, 8'h00, 1'b0);
        idle(1);
        fill(3, 8'h00, 1'b1);
        run_txn(1'b1, 1'b1, 20'h12345, 8'hC7, 1'b1);
        fill(1, 8'h00, 1'b1);
        run_txn(1'b1, 1'b0, 20'h54321, 8'h3C, 1'b0);
        idle(1);
        reset_mid_write();

        for (int t = 0; t < 40; t++) begin
            fill(int'($urandom_range(4, 0)), 8'h00, 1'b1);
            run_txn(1'($urandom), 1'($urandom), 20'($urandom), 8'($urandom), 1'($urandom));
            if (!req) idle(int'($urandom_range(3, 0)));
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
